irq_ctrl: RTL

- Interrupt controller feeding the CP0 external interrupt input (ir_out drives CP0 ir_in).
- Synchronizes and edge-detects N_SRC external lines. Also provides one internal auto-reload timer source.
- Holds pending and mask state and picks the highest-priority request.
- Runs a request/acknowledge/end-of-interrupt handshake so only one interrupt is outstanding toward CP0. Registers are accessible over a simple word bus.

---
 rtl/irq_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller in front of the CP0 external interrupt input.
// It synchronizes and edge-detects the external lines and adds one auto-reload
// timer source. Pending and mask state live here, and the highest-priority
// eligible request is forwarded. A req/ack/eoi handshake keeps at most one
// interrupt outstanding toward CP0.
module irq_ctrl #(
  parameter int N_SRC       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [2:0]       bus_addr,
  input  logic             bus_we,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  input  logic             irq_ack,
  input  logic             irq_eoi,
  output logic             ir_out,
  output logic [3:0]       irq_id
);

  // Pending/mask vectors carry the external lines plus the timer at index N_SRC
  localparam int NP = N_SRC + 1;

  localparam logic [2:0] ADDR_PEND = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd1;
  localparam logic [2:0] ADDR_CTRL = 3'd2;
  localparam logic [2:0] ADDR_TCMP = 3'd3;
  localparam logic [2:0] ADDR_TCNT = 3'd4;
  localparam logic [2:0] ADDR_CUR  = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t                              state;
  logic [SYNC_STAGES-1:0][N_SRC-1:0]   sync_q;
  logic [N_SRC-1:0]                    prev_q;
  logic [N_SRC-1:0]                    edge_det;
  logic [NP-1:0]                       pend;
  logic [NP-1:0]                       mask;
  logic [1:0]                          ctrl;
  logic [31:0]                         tcmp;
  logic [31:0]                         tcnt;
  logic                                timer_run;
  logic                                timer_match;
  logic [NP-1:0]                       eligible;
  logic                                any_elig;
  logic [3:0]                          winner;
  logic                                ack_take;
  logic [NP-1:0]                       ack_onehot;
  logic [NP-1:0]                       set_vec;
  logic [NP-1:0]                       clr_vec;
  logic [31:0]                         rd_next;
  logic                                wr_pend;
  logic                                wr_mask;
  logic                                wr_ctrl;
  logic                                wr_tcmp;
  logic                                wr_tcnt;

  assign wr_pend = bus_we && (bus_addr == ADDR_PEND);
  assign wr_mask = bus_we && (bus_addr == ADDR_MASK);
  assign wr_ctrl = bus_we && (bus_addr == ADDR_CTRL);
  assign wr_tcmp = bus_we && (bus_addr == ADDR_TCMP);
  assign wr_tcnt = bus_we && (bus_addr == ADDR_TCNT);

  // Synchronizer chain per external line followed by a previous-value flop
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

  assign timer_run   = ctrl[1] && (tcmp != 32'd0);
  assign timer_match = timer_run && (tcnt == tcmp);

  // Timer counter: a bus load beats the increment, a match reloads to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (wr_tcnt) begin
      tcnt <= bus_wdata;
    end else if (timer_run) begin
      if (timer_match) tcnt <= '0;
      else             tcnt <= tcnt + 32'd1;
    end
  end

  // Plain configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
      ctrl <= '0;
      tcmp <= '0;
    end else begin
      if (wr_mask) mask <= bus_wdata[NP-1:0];
      if (wr_ctrl) ctrl <= bus_wdata[1:0];
      if (wr_tcmp) tcmp <= bus_wdata;
    end
  end

  assign ack_take   = (state == REQ) && irq_ack;
  assign ack_onehot = {{(NP-1){1'b0}}, 1'b1} << irq_id;
  assign set_vec    = {timer_match, edge_det};
  assign clr_vec    = (wr_pend  ? bus_wdata[NP-1:0] : '0) |
                      (ack_take ? ack_onehot        : '0);

  // Pending bits: clears from W1C or acknowledge, new events take precedence
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~clr_vec) | set_vec;
  end

  assign eligible = pend & mask & {NP{ctrl[0]}};
  assign any_elig = |eligible;

  // Fixed priority: the lowest set index wins, so the timer is last
  always_comb begin
    winner = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 4'(i);
    end
  end

  // Handshake FSM; ir_out is registered alongside the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ir_out <= 1'b0;
      irq_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) begin
            state  <= REQ;
            ir_out <= 1'b1;
            irq_id <= winner;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state  <= SERVICE;
            ir_out <= 1'b0;
          end else if (!any_elig) begin
            state  <= IDLE;
            ir_out <= 1'b0;
          end else begin
            irq_id <= winner;
          end
        end
        SERVICE: begin
          if (irq_eoi) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          ir_out <= 1'b0;
        end
      endcase
    end
  end

  // Read mux selecting the addressed register; unused bits stay zero
  always_comb begin
    rd_next = '0;
    case (bus_addr)
      ADDR_PEND: rd_next[NP-1:0] = pend;
      ADDR_MASK: rd_next[NP-1:0] = mask;
      ADDR_CTRL: rd_next[1:0]    = ctrl;
      ADDR_TCMP: rd_next         = tcmp;
      ADDR_TCNT: rd_next         = tcnt;
      ADDR_CUR:  rd_next         = {(state == SERVICE), 27'd0, irq_id};
      default:   rd_next         = '0;
    endcase
  end

  // Registered read data, one cycle behind the address
  always_ff @(posedge clk) begin
    if (rst) bus_rdata <= '0;
    else     bus_rdata <= rd_next;
  end

endmodule
